// File: rtl/miniLA_pkg.sv
// Shared types and constants for the miniLA front end.
package miniLA_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0340_0000;  // andi r0,r0,0

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction-memory request/response bus plus the decode-side drain port of the fetch queue.
interface ifetch_queue_if;
  import miniLA_pkg::*;

  // Handshakes: imem issue happens on imem_req_o & imem_gnt_i; a response is one cycle with
  // imem_rvalid_i high, in issue order; decode pops the head on id_valid_o & id_ready_i.
  // A valid never depends on its own ready.
  logic              imem_req_o;
  logic [XLEN-1:0]   imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [INST_W-1:0] imem_rdata_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [XLEN-1:0]   id_pc_o;
  logic [INST_W-1:0] id_inst_o;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

endinterface

// File: rtl/ifq_ring.sv
// Fetch queue storage: ring of {pc, inst, filled} with head, response and allocation pointers.
module ifq_ring
  import miniLA_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_i,
  input  logic [XLEN-1:0]          issue_pc_i,
  input  logic                     wr_i,
  input  logic [INST_W-1:0]        wr_inst_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic                     head_valid_o,
  output logic [XLEN-1:0]          head_pc_o,
  output logic [INST_W-1:0]        head_inst_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]      rsp_ptr_q, rsp_ptr_d;
  logic [PW:0]      alloc_ptr_q, alloc_ptr_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  ifq_entry_t       slot_q [DEPTH];
  ifq_entry_t       slot_d [DEPTH];

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rsp_ptr_d   = rsp_ptr_q;
    alloc_ptr_d = alloc_ptr_q;
    filled_d    = filled_q;
    slot_d      = slot_q;
    if (flush_i) begin
      // Everything queued or awaiting data is abandoned; stale filled bits are masked by occ == 0.
      rd_ptr_d  = alloc_ptr_q;
      rsp_ptr_d = alloc_ptr_q;
    end else begin
      if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_i) begin
        slot_d[rsp_ptr_q[PW-1:0]].inst = wr_inst_i;
        filled_d[rsp_ptr_q[PW-1:0]]    = 1'b1;
        rsp_ptr_d                      = rsp_ptr_q + 1'b1;
      end
      if (issue_i) begin
        slot_d[alloc_ptr_q[PW-1:0]].pc = issue_pc_i;
        filled_d[alloc_ptr_q[PW-1:0]]  = 1'b0;
        alloc_ptr_d                    = alloc_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      rsp_ptr_q   <= '0;
      alloc_ptr_q <= '0;
      filled_q    <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rsp_ptr_q   <= rsp_ptr_d;
      alloc_ptr_q <= alloc_ptr_d;
      filled_q    <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign occ_o        = alloc_ptr_q - rd_ptr_q;
  assign head_valid_o = filled_q[rd_ptr_q[PW-1:0]] & (occ_o != '0);
  assign head_pc_o    = slot_q[rd_ptr_q[PW-1:0]].pc;
  assign head_inst_o  = slot_q[rd_ptr_q[PW-1:0]].inst;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: issues imem requests from the PC, throttles the PC, buffers in-order responses for decode.
module ifetch_queue
  import miniLA_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            pc_stop_o,
  ifetch_queue_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW:0]   inflight;
  logic [PW:0]   occ;
  logic          head_valid;
  logic          issue, rsp_drop, rsp_wr, pop;

  assign inflight = {1'b0, out_cnt_q} + {1'b0, drop_cnt_q};

  assign bus.imem_req_o  = !rst && !flush_i && (occ < (PW+1)'(DEPTH)) && (inflight < (CW+1)'(MAX_OUT));
  assign bus.imem_addr_o = pc_i;
  assign issue           = bus.imem_req_o & bus.imem_gnt_i;
  assign pc_stop_o       = !issue && !flush_i;

  assign rsp_drop = bus.imem_rvalid_i && (drop_cnt_q != '0);
  assign rsp_wr   = bus.imem_rvalid_i && (drop_cnt_q == '0) && !flush_i;
  assign pop      = head_valid && bus.id_ready_i && !flush_i;

  always_comb begin
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      // Every response still owed becomes a drop; one arriving now is consumed whichever count owns it.
      drop_cnt_d = drop_cnt_q + out_cnt_q - CW'(bus.imem_rvalid_i);
      out_cnt_d  = '0;
    end else begin
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
      out_cnt_d  = out_cnt_q + CW'(issue) - CW'(rsp_wr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (issue),
    .issue_pc_i   (pc_i),
    .wr_i         (rsp_wr),
    .wr_inst_i    (bus.imem_rdata_i),
    .pop_i        (pop),
    .flush_i      (flush_i),
    .occ_o        (occ),
    .head_valid_o (head_valid),
    .head_pc_o    (bus.id_pc_o),
    .head_inst_o  (bus.id_inst_o)
  );

  assign bus.id_valid_o = head_valid;

  a_rvalid_owed : assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid_i |-> (inflight != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized and directed bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;
  import miniLA_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        pc_stop_o;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_i      (pc_i),
    .flush_i   (flush_i),
    .pc_stop_o (pc_stop_o),
    .bus       (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: delivered-order queue plus in-flight list with drop marks
  ent_t        exp_q[$];
  logic [31:0] fl_pc[$];
  bit          fl_drop[$];
  logic [31:0] pc;

  int n_chk  = 0;
  int n_fail = 0;
  int n_issue = 0;
  bit          obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    fl_pc.delete();
    fl_drop.delete();
  endtask

  // driver: one clock cycle with the given controls; checks outputs mid-cycle, updates model at the edge
  task automatic cycle(input bit gnt, input bit rv, input bit rdy, input bit fl, input logic [31:0] tgt);
    bit m_req, m_valid, issue, do_rv, dr;
    @(negedge clk);
    do_rv              = rv && !rst && (fl_pc.size() > 0);
    flush_i            = fl;
    bus.imem_gnt_i     = gnt;
    bus.id_ready_i     = rdy;
    bus.imem_rvalid_i  = do_rv;
    bus.imem_rdata_i   = (do_rv && !fl_drop[0]) ? inst_of(fl_pc[0]) : $urandom;
    pc_i               = pc;
    #1;
    m_req   = !rst && !fl && (exp_q.size() < DEPTH) && (fl_pc.size() < MAX_OUT);
    m_valid = (exp_q.size() > 0) && exp_q[0].filled;
    issue   = m_req && gnt;
    check_eq("imem_req", 32'(bus.imem_req_o), 32'(m_req));
    check_eq("pc_stop", 32'(pc_stop_o), 32'(!issue && !fl));
    if (m_req) check_eq("imem_addr", bus.imem_addr_o, pc);
    check_eq("id_valid", 32'(bus.id_valid_o), 32'(m_valid));
    if (m_valid) begin
      check_eq("id_pc", bus.id_pc_o, exp_q[0].pc);
      check_eq("id_inst", bus.id_inst_o, exp_q[0].inst);
    end
    obs_valid = bus.id_valid_o;
    obs_pc    = bus.id_pc_o;
    obs_addr  = bus.imem_addr_o;
    if (bus.imem_req_o && gnt) n_issue++;
    @(posedge clk);
    if (!rst) begin
      if (do_rv) begin
        void'(fl_pc.pop_front());
        dr = fl_drop.pop_front();
        if (!dr && !fl) begin
          for (int i = 0; i < exp_q.size(); i++) begin
            if (!exp_q[i].filled) begin
              exp_q[i].inst   = bus.imem_rdata_i;
              exp_q[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (fl) begin
        exp_q.delete();
        foreach (fl_drop[i]) fl_drop[i] = 1'b1;
        pc = tgt;
      end else begin
        if (m_valid && rdy) void'(exp_q.pop_front());
        if (issue) begin
          exp_q.push_back('{pc: pc, inst: 32'h0, filled: 1'b0});
          fl_pc.push_back(pc);
          fl_drop.push_back(1'b0);
          pc = pc + 32'd4;
        end
      end
    end
  endtask

  task automatic drain();
    repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    int base;
    int first_seen;
    logic [31:0] addr0;

    rst = 1'b1;
    flush_i = 1'b0;
    pc_i = '0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.id_ready_i = 1'b0;
    pc = 32'h0;
    model_clear();

    // power-on reset
    repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #2 rst = 1'b0;

    // mid-run reset with 2 in flight
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    model_clear();
    pc = 32'h0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #2 rst = 1'b0;

    // streaming from pc 0
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // backpressure: 4 grants then held, one pop frees one slot
    base = n_issue;
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("bp_grants", n_issue - base, 4);
    base = n_issue;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("bp_refill", n_issue - base, 1);
    drain();

    // flush with 2 outstanding and 1 queued
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1C00_0100);
    first_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_valid && first_seen == 0) begin
        first_seen = 1;
        check_eq("flush_first_pc", obs_pc, 32'h1C00_0100);
      end
    end
    if (first_seen == 0) check_eq("flush_first_seen", 32'(first_seen), 32'd1);
    drain();

    // flush coinciding with rvalid and pop
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    repeat (8) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // stalling memory: address and stop held
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    addr0 = obs_addr;
    repeat (5) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("stall_addr", obs_addr, addr0);
      check_eq("stall_stop", 32'(pc_stop_o), 32'd1);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        model_clear();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        #2 rst = 1'b0;
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
